// File: rtl/exception_commit_unit.sv
// Exception/ERET commit unit: updates CP0 EPC/Cause/Status, flushes the pipeline, then redirects the PC.
// Optional feature macro BADVADDR_EN adds a BadVAddr register captured on address-error exceptions.
module exception_commit_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        int_req,
  input  logic        eret_req,
  input  logic [31:0] vic_inst_addr,
  input  logic        vic_is_delayslot,
`ifdef BADVADDR_EN
  input  logic [31:0] bad_addr_i,
  output logic [31:0] badvaddr_o,
`endif
  output logic        flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic [31:0] epc_o,
  output logic        cause_bd_o,
  output logic [4:0]  cause_exccode_o,
  output logic        status_exl_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic [31:0] tgt_r;
  logic [31:0] epc_r;
  logic        bd_r;
  logic [4:0]  exccode_r;
  logic        exl_r;
  logic        take_int, take_exc, take_eret;

  // Request arbitration; only IDLE accepts, an interrupt is masked while EXL is set.
  always_comb begin
    take_int  = 1'b0;
    take_exc  = 1'b0;
    take_eret = 1'b0;
    if (state_r == IDLE) begin
      take_int  = int_req & ~exl_r;
      take_exc  = ~take_int & exc_req;
      take_eret = ~take_int & ~exc_req & eret_req;
    end else begin
      take_int  = 1'b0;
      take_exc  = 1'b0;
      take_eret = 1'b0;
    end
  end

  // Sequencer next-state and flush counter.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      IDLE: begin
        if (take_int | take_exc | take_eret) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_r == 4'd0) begin
          state_nx = REDIRECT;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // CP0 commit; a nested exception keeps the original EPC/BD so the first victim is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_r     <= 32'd0;
      epc_r     <= 32'd0;
      bd_r      <= 1'b0;
      exccode_r <= 5'd0;
      exl_r     <= 1'b0;
    end else if (take_int | take_exc) begin
      exccode_r <= take_int ? 5'd0 : exc_code;
      exl_r     <= 1'b1;
      tgt_r     <= EXC_VECTOR;
      if (!exl_r) begin
        epc_r <= vic_is_delayslot ? (vic_inst_addr - 32'd4) : vic_inst_addr;
        bd_r  <= vic_is_delayslot;
      end
    end else if (take_eret) begin
      exl_r <= 1'b0;
      tgt_r <= epc_r;
    end
  end

`ifdef BADVADDR_EN
  logic [31:0] badvaddr_r;

  // BadVAddr captures only on accepted AdEL/AdES exceptions.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_r <= 32'd0;
    end else if (take_exc && ((exc_code == 5'd4) || (exc_code == 5'd5))) begin
      badvaddr_r <= bad_addr_i;
    end
  end

  assign badvaddr_o = badvaddr_r;
`endif

  assign busy_o          = (state_r != IDLE);
  assign flush_o         = (state_r != IDLE);
  assign pc_redirect_o   = (state_r == REDIRECT);
  assign pc_target_o     = (state_r == REDIRECT) ? tgt_r : 32'd0;
  assign epc_o           = epc_r;
  assign cause_bd_o      = bd_r;
  assign cause_exccode_o = exccode_r;
  assign status_exl_o    = exl_r;

endmodule
